// File: rtl/md_defs.sv
// md_defs: shared MD op codes and default latencies for the multiply/divide unit.
package md_defs;
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_t;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational {hi,lo} result for mult/multu/div/divu plus divide-by-zero hold flag.
module md_calc
    import md_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        hold
);
    logic        sgn, is_div, neg_q, neg_r;
    logic [31:0] num, den, den_nz, quo, rem;
    logic [63:0] mul_a, mul_b;
    always_comb begin
        sgn    = op == MD_MULT || op == MD_DIV;
        is_div = op == MD_DIV || op == MD_DIVU;
        mul_a  = {{32{sgn & rs_val[31]}}, rs_val};
        mul_b  = {{32{sgn & rt_val[31]}}, rt_val};
        // divide on magnitudes, then restore signs: quotient truncates, remainder follows dividend
        num    = sgn && rs_val[31] ? -rs_val : rs_val;
        den    = sgn && rt_val[31] ? -rt_val : rt_val;
        den_nz = den == '0 ? 32'd1 : den;
        quo    = num / den_nz;
        rem    = num % den_nz;
        neg_q  = sgn & (rs_val[31] ^ rt_val[31]);
        neg_r  = sgn & rs_val[31];
        hold   = is_div && rt_val == '0;
        result = is_div ? {neg_r ? -rem : rem, neg_q ? -quo : quo} : mul_a * mul_b;
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit holding HI/LO with fixed multi-cycle latency.
module mult_div_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);
    logic [15:0] cnt;
    logic [31:0] pend_hi, pend_lo;
    logic [63:0] result;
    logic        hold, accept, is_mul, is_div;
    md_calc u_calc (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .result (result),
        .hold   (hold)
    );
    always_comb begin
        busy   = cnt != '0;
        accept = start & ~cancel & ~busy;
        is_mul = op == MD_MULT || op == MD_MULTU;
        is_div = op == MD_DIV || op == MD_DIVU;
        rdata  = op == MD_MFHI ? hi : op == MD_MFLO ? lo : '0;
    end
    // HI/LO cannot change while busy, so a divide-by-zero simply re-commits the current values
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (cnt == 16'd1) begin
            hi  <= pend_hi;
            lo  <= pend_lo;
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt - 16'd1;
        end else if (accept) begin
            if (op == MD_MTHI) hi <= rs_val;
            if (op == MD_MTLO) lo <= rs_val;
            if (is_mul || is_div) begin
                {pend_hi, pend_lo} <= hold ? {hi, lo} : result;
                cnt <= is_mul ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a scoreboard checking busy length and HI/LO at each completion.
module tb_mult_div_unit;
    import md_defs::*;
    logic        clk = 1'b0;
    logic        reset, start, cancel, busy;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val, hi, lo, rdata;
    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, run = 0;
    always #5 clk = ~clk;
    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask
    // monitor: a completed busy run pops one expected result
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy === 1'b1) run++;
        else if (run > 0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got run %0d expected none", run);
            end else begin
                e = q.pop_front();
                check("busy_cycles", 32'(run), 32'(e.cycles));
                check("done_hi", hi, e.hi);
                check("done_lo", lo, e.lo);
            end
            run = 0;
        end
    end
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c = 1'b0);
        @(posedge clk); #2;
        start = 1'b1; cancel = c; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #2;
        start = 1'b0; cancel = 1'b0; op = MD_NONE;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask
    task automatic md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int cyc, input logic [31:0] eh, input logic [31:0] el);
        q.push_back('{cyc, eh, el});
        issue(o, a, b);
        wait_idle();
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_NONE; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        op = MD_MFHI; #1;
        check("reset_rdata", rdata, 32'h0);
        op = MD_NONE;
        md(MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        md(MD_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(negedge clk);
        op = MD_MFLO; #1;
        check("mflo_rdata", rdata, 32'hFFFFFFF1);
        op = MD_MFHI; #1;
        check("mfhi_rdata", rdata, 32'hFFFFFFFF);
        op = MD_NONE; #1;
        check("none_rdata", rdata, 32'h0);
        md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        md(MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md(MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        md(MD_DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E);
        md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        md(MD_DIVU, 32'h12345678, 32'h0, 10, 32'h00000000, 32'h80000000);
        issue(MD_MTHI, 32'h0000ABCD, 32'h0);
        check("mthi_hi", hi, 32'h0000ABCD);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        issue(MD_MTHI, 32'h00001234, 32'h0, 1'b1);
        check("cancel_hi", hi, 32'h0000ABCD);
        issue(MD_MTLO, 32'h00000055, 32'h0);
        check("mtlo_lo", lo, 32'h00000055);
        check("mtlo_hi", hi, 32'h0000ABCD);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        q.push_back('{3, 32'h0, 32'h0});
        issue(MD_MULT, 32'd7, 32'd9);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        repeat (6) @(posedge clk);
        #2;
        check("rst_late_hi", hi, 32'h0);
        check("rst_late_lo", lo, 32'h0);
        check("rst_late_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
